// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings used by the bus slaves in this slice.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY = 1'b0;

endpackage

// File: rtl/ahb_byte_mask.sv
// Combinational AHB byte-lane mask from transfer size and low address bits.
module ahb_byte_mask
  import ahb_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] addr_i,
  output logic [3:0] mask_o
);

  // Misaligned low bits are dropped; sizes above word collapse to a full word.
  always_comb begin
    mask_o = 4'b1111;
    case (hsize_i)
      HSIZE_BYTE: mask_o = 4'b0001 << addr_i;
      HSIZE_HALF: mask_o = 4'b0011 << {addr_i[1], 1'b0};
      default:    mask_o = 4'b1111;
    endcase
  end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// Zero-wait-state AHB-Lite slave in front of a dual-port BRAM, with a one-entry
// byte-merge forwarding register covering read-during-write on the same word.
module ahb_bram_ctrl
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDRA,
  output logic [3:0]            BRAM_WE,
  output logic [31:0]           BRAM_WDATA,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDRB,
  input  logic [31:0]           BRAM_RDATA
);

  logic                  accept;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [3:0]            mask;

  logic                  wr_pend_q, wr_pend_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  fwd_hit_q, fwd_hit_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [3:0]            wr_mask_q, wr_mask_d;
  logic [3:0]            fwd_mask_q, fwd_mask_d;
  logic [31:0]           fwd_data_q, fwd_data_d;

  logic unused_bits;
  assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  assign accept    = HSEL & HTRANS[1] & HREADY;
  assign word_addr = HADDR[ADDR_WIDTH+1:2];

  ahb_byte_mask u_byte_mask (
    .hsize_i (HSIZE),
    .addr_i  (HADDR[1:0]),
    .mask_o  (mask)
  );

  // Everything holds while another slave stretches the data phase.
  always_comb begin
    wr_pend_d  = wr_pend_q;
    rd_pend_d  = rd_pend_q;
    fwd_hit_d  = fwd_hit_q;
    wr_addr_d  = wr_addr_q;
    wr_mask_d  = wr_mask_q;
    fwd_mask_d = fwd_mask_q;
    fwd_data_d = fwd_data_q;
    if (HREADY) begin
      wr_pend_d = accept & HWRITE;
      rd_pend_d = accept & ~HWRITE;
      fwd_hit_d = 1'b0;
      if (accept && HWRITE) begin
        wr_addr_d = word_addr;
        wr_mask_d = mask;
      end
      // RAM returns pre-write data on a same-word collision; capture the new bytes.
      if (accept && !HWRITE && wr_pend_q && (word_addr == wr_addr_q)) begin
        fwd_hit_d  = 1'b1;
        fwd_data_d = HWDATA;
        fwd_mask_d = wr_mask_q;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_pend_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      fwd_hit_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_mask_q  <= '0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else begin
      wr_pend_q  <= wr_pend_d;
      rd_pend_q  <= rd_pend_d;
      fwd_hit_q  <= fwd_hit_d;
      wr_addr_q  <= wr_addr_d;
      wr_mask_q  <= wr_mask_d;
      fwd_mask_q <= fwd_mask_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  assign BRAM_ADDRA = wr_addr_q;
  assign BRAM_WE    = wr_pend_q ? wr_mask_q : 4'b0000;
  assign BRAM_WDATA = HWDATA;
  assign BRAM_ADDRB = word_addr;

  always_comb begin
    HRDATA = '0;
    if (rd_pend_q) begin
      for (int i = 0; i < 4; i++) begin
        HRDATA[8*i +: 8] = (fwd_hit_q && fwd_mask_q[i]) ? fwd_data_q[8*i +: 8]
                                                        : BRAM_RDATA[8*i +: 8];
      end
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = HRESP_OKAY;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Directed self-checking bench for ahb_bram_ctrl with a behavioural BRAM model.
module tb_ahb_bram_ctrl;

  localparam int unsigned AW = 14;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [AW-1:0] BRAM_ADDRA;
  logic [3:0]    BRAM_WE;
  logic [31:0]   BRAM_WDATA;
  logic [AW-1:0] BRAM_ADDRB;
  logic [31:0]   BRAM_RDATA;

  int total = 0;
  int bad   = 0;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [31:0]   pl_data = '0;

  always #5 HCLK = ~HCLK;

  ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .HSEL       (HSEL),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HSIZE      (HSIZE),
    .HWRITE     (HWRITE),
    .HWDATA     (HWDATA),
    .HREADY     (HREADY),
    .HREADYOUT  (HREADYOUT),
    .HRESP      (HRESP),
    .HRDATA     (HRDATA),
    .BRAM_ADDRA (BRAM_ADDRA),
    .BRAM_WE    (BRAM_WE),
    .BRAM_WDATA (BRAM_WDATA),
    .BRAM_ADDRB (BRAM_ADDRB),
    .BRAM_RDATA (BRAM_RDATA)
  );

  // Read-first RAM: a same-address read in the write cycle returns old data.
  always @(posedge HCLK) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    for (int i = 0; i < 4; i++) begin
      if (BRAM_WE[i]) mem[BRAM_ADDRA][8*i +: 8] <= BRAM_WDATA[8*i +: 8];
    end
    BRAM_RDATA <= mem[BRAM_ADDRB];
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_bus();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HSIZE  = 3'd2;
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] a, input logic [2:0] sz);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HADDR  = a;
    HSIZE  = sz;
    HWRITE = wr;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    HREADY  = 1'b1;
    HWDATA  = 32'h0;
    HADDR   = 32'h0;
    idle_bus();
    #12;
    total++; if (BRAM_WE !== 4'h0) begin bad++; $display("FAIL reset_we: got %h want 0", BRAM_WE); end
    total++; if (HRDATA !== 32'h0) begin bad++; $display("FAIL reset_hrdata: got %h want 0", HRDATA); end
    total++; if (HREADYOUT !== 1'b1) begin bad++; $display("FAIL reset_hreadyout: got %b want 1", HREADYOUT); end
    total++; if (HRESP !== 1'b0) begin bad++; $display("FAIL reset_hresp: got %b want 0", HRESP); end
    addr_phase(1'b1, 32'h2000_0000, 3'd2);
    tick();
    total++; if (BRAM_WE !== 4'h0) begin bad++; $display("FAIL reset_no_accept: got %h want 0", BRAM_WE); end
    idle_bus();
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_word_write_read();
    preload(14'd4, 32'h0);
    addr_phase(1'b1, 32'h2000_0010, 3'd2);
    tick();
    HWDATA = 32'hDEAD_BEEF;
    idle_bus();
    total++; if (BRAM_WE !== 4'hF) begin bad++; $display("FAIL word_we: got %h want f", BRAM_WE); end
    total++; if (BRAM_ADDRA !== 14'd4) begin bad++; $display("FAIL word_addra: got %0d want 4", BRAM_ADDRA); end
    tick();
    HWDATA = 32'h0;
    total++; if (BRAM_WE !== 4'h0) begin bad++; $display("FAIL word_we_idle: got %h want 0", BRAM_WE); end
    addr_phase(1'b0, 32'h2000_0010, 3'd2);
    tick();
    idle_bus();
    total++; if (HRDATA !== 32'hDEAD_BEEF) begin bad++; $display("FAIL word_read: got %h want deadbeef", HRDATA); end
    tick();
    total++; if (HRDATA !== 32'h0) begin bad++; $display("FAIL word_hrdata_idle: got %h want 0", HRDATA); end
  endtask

  task automatic test_byte_write();
    preload(14'd8, 32'h1122_3344);
    addr_phase(1'b1, 32'h2000_0022, 3'd0);
    tick();
    HWDATA = 32'h0055_0000;
    idle_bus();
    total++; if (BRAM_WE !== 4'b0100) begin bad++; $display("FAIL byte_we: got %b want 0100", BRAM_WE); end
    tick();
    tick();
    addr_phase(1'b0, 32'h2000_0020, 3'd2);
    tick();
    idle_bus();
    total++; if (HRDATA !== 32'h1155_3344) begin bad++; $display("FAIL byte_read: got %h want 11553344", HRDATA); end
    tick();
  endtask

  task automatic test_forward();
    preload(14'd12, 32'h0);
    preload(14'd13, 32'h1122_3344);
    addr_phase(1'b1, 32'h2000_0032, 3'd1);
    tick();
    HWDATA = 32'hABCD_0000;
    addr_phase(1'b0, 32'h2000_0030, 3'd2);
    total++; if (BRAM_WE !== 4'b1100) begin bad++; $display("FAIL fwd_half_we: got %b want 1100", BRAM_WE); end
    tick();
    HWDATA = 32'h0;
    idle_bus();
    total++; if (HRDATA !== 32'hABCD_0000) begin bad++; $display("FAIL fwd_half: got %h want abcd0000", HRDATA); end
    tick();
    // Misaligned half at offset 1 acts as offset 0.
    addr_phase(1'b1, 32'h2000_0035, 3'd1);
    tick();
    HWDATA = 32'h0000_BEEF;
    addr_phase(1'b0, 32'h2000_0034, 3'd2);
    total++; if (BRAM_WE !== 4'b0011) begin bad++; $display("FAIL fwd_mis_we: got %b want 0011", BRAM_WE); end
    tick();
    HWDATA = 32'h0;
    idle_bus();
    total++; if (HRDATA !== 32'h1122_BEEF) begin bad++; $display("FAIL fwd_mis: got %h want 1122beef", HRDATA); end
    tick();
  endtask

  task automatic test_no_forward();
    preload(14'd6, 32'h0BAD_F00D);
    addr_phase(1'b1, 32'h2000_0014, 3'd2);
    tick();
    HWDATA = 32'h1234_5678;
    addr_phase(1'b0, 32'h2000_0018, 3'd2);
    tick();
    HWDATA = 32'h0;
    addr_phase(1'b0, 32'h2000_0014, 3'd2);
    total++; if (HRDATA !== 32'h0BAD_F00D) begin bad++; $display("FAIL nofwd_w6: got %h want 0badf00d", HRDATA); end
    tick();
    idle_bus();
    total++; if (HRDATA !== 32'h1234_5678) begin bad++; $display("FAIL nofwd_w5: got %h want 12345678", HRDATA); end
    tick();
  endtask

  task automatic test_back_to_back();
    addr_phase(1'b1, 32'h2000_0050, 3'd2);
    tick();
    HWDATA = 32'hA0A0_A0A0;
    addr_phase(1'b1, 32'h2000_0054, 3'd2);
    tick();
    HWDATA = 32'hA1A1_A1A1;
    addr_phase(1'b1, 32'h2000_0058, 3'd2);
    tick();
    HWDATA = 32'hA2A2_A2A2;
    addr_phase(1'b0, 32'h2000_0050, 3'd2);
    total++; if (BRAM_ADDRA !== 14'd22) begin bad++; $display("FAIL b2b_addra: got %0d want 22", BRAM_ADDRA); end
    total++; if (BRAM_WE !== 4'hF) begin bad++; $display("FAIL b2b_we: got %h want f", BRAM_WE); end
    tick();
    HWDATA = 32'h0;
    addr_phase(1'b0, 32'h2000_0054, 3'd2);
    total++; if (HRDATA !== 32'hA0A0_A0A0) begin bad++; $display("FAIL b2b_r20: got %h want a0a0a0a0", HRDATA); end
    total++; if (BRAM_WE !== 4'h0) begin bad++; $display("FAIL b2b_we_rd: got %h want 0", BRAM_WE); end
    tick();
    addr_phase(1'b0, 32'h2000_0058, 3'd2);
    total++; if (HRDATA !== 32'hA1A1_A1A1) begin bad++; $display("FAIL b2b_r21: got %h want a1a1a1a1", HRDATA); end
    tick();
    idle_bus();
    total++; if (HRDATA !== 32'hA2A2_A2A2) begin bad++; $display("FAIL b2b_r22: got %h want a2a2a2a2", HRDATA); end
    tick();
  endtask

  task automatic test_hready_stall();
    preload(14'd30, 32'h0);
    preload(14'd31, 32'h3131_3131);
    addr_phase(1'b1, 32'h2000_0078, 3'd2);
    tick();
    HWDATA = 32'h5A5A_A5A5;
    HREADY = 1'b0;
    addr_phase(1'b1, 32'h2000_007C, 3'd2);
    for (int c = 0; c < 3; c++) begin
      total++; if (BRAM_WE !== 4'hF || BRAM_ADDRA !== 14'd30) begin
        bad++; $display("FAIL stall_hold%0d: got we=%h addr=%0d want we=f addr=30", c, BRAM_WE, BRAM_ADDRA);
      end
      tick();
    end
    HREADY = 1'b1;
    idle_bus();
    total++; if (BRAM_WE !== 4'hF) begin bad++; $display("FAIL stall_rise_we: got %h want f", BRAM_WE); end
    tick();
    HWDATA = 32'h0;
    total++; if (BRAM_WE !== 4'h0) begin bad++; $display("FAIL stall_done_we: got %h want 0", BRAM_WE); end
    addr_phase(1'b0, 32'h2000_0078, 3'd2);
    tick();
    addr_phase(1'b0, 32'h2000_007C, 3'd2);
    total++; if (HRDATA !== 32'h5A5A_A5A5) begin bad++; $display("FAIL stall_r30: got %h want 5a5aa5a5", HRDATA); end
    tick();
    idle_bus();
    total++; if (HRDATA !== 32'h3131_3131) begin bad++; $display("FAIL stall_r31: got %h want 31313131", HRDATA); end
    tick();
  endtask

  task automatic test_reset_mid_write();
    preload(14'd40, 32'h0102_0304);
    addr_phase(1'b1, 32'h2000_00A0, 3'd2);
    tick();
    HWDATA = 32'hFFFF_FFFF;
    idle_bus();
    total++; if (BRAM_WE !== 4'hF) begin bad++; $display("FAIL rstw_we_pre: got %h want f", BRAM_WE); end
    #2;
    HRESETn = 1'b0;
    #1;
    total++; if (BRAM_WE !== 4'h0) begin bad++; $display("FAIL rstw_we_drop: got %h want 0", BRAM_WE); end
    total++; if (HREADYOUT !== 1'b1) begin bad++; $display("FAIL rstw_hreadyout: got %b want 1", HREADYOUT); end
    tick();
    HWDATA  = 32'h0;
    HRESETn = 1'b1;
    tick();
    addr_phase(1'b0, 32'h2000_00A0, 3'd2);
    tick();
    idle_bus();
    total++; if (HRDATA !== 32'h0102_0304) begin bad++; $display("FAIL rstw_word: got %h want 01020304", HRDATA); end
    total++; if (HREADYOUT !== 1'b1) begin bad++; $display("FAIL rstw_hreadyout_after: got %b want 1", HREADYOUT); end
    tick();
  endtask

  initial begin
    test_reset();
    test_word_write_read();
    test_byte_write();
    test_forward();
    test_no_forward();
    test_back_to_back();
    test_hready_stall();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_bram_ctrl.md
Name: ahb_bram_ctrl

Overview:
AHB-Lite slave that fronts the SoC's dual-port block RAM and converts bus transfers into its port signals. It drives the byte-enabled write port (port A) and the registered read port (port B). The block sits between the bus matrix and the RAM instance. It resolves read-after-write hazards with a one-entry byte-merge forwarding register, so every transfer completes with zero wait states.

Parameters:
- ADDR_WIDTH, 14, RAM word-address width; decodes HADDR[ADDR_WIDTH+1:2].

Ports:
- HCLK  in  1  bus clock; also clocks the RAM.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HTRANS  in  2  transfer type; bit1=1 means NONSEQ/SEQ.
- HSIZE  in  3  0=byte, 1=half, 2=word.
- HWRITE  in  1  1=write.
- HWDATA  in  32  write data, data phase.
- HREADY  in  1  bus-wide ready.
- HREADYOUT  out  1  slave ready; constant 1.
- HRESP  out  1  constant 0 (OKAY).
- HRDATA  out  32  read data, data phase.
- BRAM_ADDRA  out  ADDR_WIDTH  write word address.
- BRAM_WE  out  4  byte write enables.
- BRAM_WDATA  out  32  write data.
- BRAM_ADDRB  out  ADDR_WIDTH  read word address.
- BRAM_RDATA  in  32  RAM registered read data; valid one clock after BRAM_ADDRB is sampled.

Behaviour:
- Transfer accepted when HSEL & HTRANS[1] & HREADY are high at a rising edge (address phase).
- Byte mask from HSIZE/HADDR[1:0]:
  - byte: 1<<A[1:0]
  - half: 4'b0011<<{A[1],1'b0}
  - word: 4'b1111
  - HSIZE>2 is treated as word.
  - Misaligned low bits are ignored, e.g. half at A[1:0]=1 is treated as A[1:0]=0.
- Write path:
  - On accepted write, register wr_pend=1, wr_addr (word), wr_mask.
  - In the next cycle (data phase), BRAM_ADDRA=wr_addr, BRAM_WE=wr_mask, BRAM_WDATA=HWDATA, all combinational.
  - BRAM_WE=0 whenever wr_pend=0.
  - RAM commits at the end of the data phase.
- Read path:
  - BRAM_ADDRB = HADDR word bits, combinational, every cycle.
  - On accepted read, register rd_pend=1.
  - HRDATA in the data phase = BRAM_RDATA, with forwarding merge applied.
  - HRDATA=0 when no read data phase is active.
- Forwarding:
  - If an accepted read's word address equals wr_addr while wr_pend=1, RAM returns old data (read-during-write).
  - In that case latch fwd_data=HWDATA and fwd_mask=wr_mask at that edge, and set fwd_hit.
  - In the read data phase, for each byte i: HRDATA byte = fwd_mask[i] ? fwd_data byte : BRAM_RDATA byte.
  - Only the immediately preceding write can collide. Older writes are already in the RAM.
- Pending flags:
  - wr_pend, rd_pend and fwd_hit clear at the next edge unless a new transfer is accepted.
  - Back-to-back writes and alternating write/read streams run at one transfer per clock.
- IDLE/BUSY or HSEL=0: no new phase. A pending data phase still completes.
- HREADY=0 from another slave: no acceptance. Pending-phase registers are held while HREADY=0.
- Reset (async, HRESETn low): wr_pend, rd_pend, fwd_hit, wr_addr, wr_mask, fwd_* all 0. Outputs: BRAM_WE=0, HRDATA=0, HREADYOUT=1, HRESP=0.
- Reset asserted mid-write data phase: BRAM_WE drops immediately and no write occurs.

Decomposition:
- Shared package ahb_pkg: HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HSIZE encodings, HRESP_OKAY.
- One sub-module, ahb_byte_mask: combinational HSIZE/A[1:0] -> 4-bit mask. It is reused by other AHB slaves.

Test Plan:
- Word write 0x20000010 <= 0xDEADBEEF, then a read two cycles later:
  - BRAM_WE=4'hF and BRAM_ADDRA=4 in the data phase.
  - The read returns 0xDEADBEEF.
- Byte write 0x55 at offset 2 over a word holding 0x11223344, then read: returns 0x11553344.
- Half write 0xABCD at offset 2 immediately followed by a read of the same word (RAM holds 0x00000000): returns 0xABCD0000 via forwarding.
- Write to word 5 immediately followed by a read of word 6: no forwarding; returns the RAM content of word 6.
- Accepted write, then HREADY=0 for 3 cycles from another slave:
  - The write data phase holds.
  - BRAM_WE is asserted until the cycle HREADY rises.
  - Exactly one commit occurs.
- Assert HRESETn=0 during a write data phase: BRAM_WE=0 within the same cycle; the word is unchanged afterwards; HREADYOUT=1 throughout.
